// File: rtl/rgb_pwm_driver_pkg.sv
// Shared definitions for the RGB PWM driver: FSM encoding, PWM frame length
// and duty width.
package rgb_pwm_driver_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ticks per PWM frame; the counter runs 0..PWM_PERIOD-1.
  localparam int PWM_PERIOD = 255;

  // Width of one colour duty value and of the PWM counter.
  localparam int DUTY_W = 8;

  // Last PWM counter value before the frame wraps.
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);

endpackage

// File: rtl/rgb_pwm_driver_channel.sv
// One PWM output: the LED is high while the shared frame counter is below
// this channel's duty. Output is registered, so it lags the counter by one clk.
module pwm_channel
  import rgb_pwm_driver_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] count,
  input  logic [DUTY_W-1:0] duty,
  output logic              led
);

  // Compare counter against duty; forced low while the driver is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      led <= en && (count < duty);
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB PWM driver: prescaler, shared 255-tick frame counter, a one-deep
// pending colour buffer with ready/valid acceptance, and three PWM channels.
// A new colour only becomes active on a frame boundary, so a frame is never
// rendered with a mix of old and new duties.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb,
  input  logic        rgb_valid,
  output logic        rgb_ready,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        frame_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [PW-1:0]     ps_cnt_reg;
  logic [DUTY_W-1:0] pwm_cnt_reg;
  logic [23:0]       active_reg;
  logic [23:0]       pending_reg;
  logic              pend_full_reg;
  logic              frame_start_reg;
  logic [2:0]        led_vec;

  logic run;
  logic go;
  logic tick;
  logic wrap;
  logic accept;

  assign rgb_ready = !pend_full_reg;
  assign accept    = rgb_valid && rgb_ready;
  assign tick      = run && (ps_cnt_reg == PS_LAST);
  assign wrap      = tick && (pwm_cnt_reg == CNT_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: the first accepted colour starts the PWM; only reset stops it.
  always_comb begin
    state_next = state_reg;
    if (state_reg == IDLE && accept) begin
      state_next = RUN;
    end
  end

  // FSM outputs: run enables counting and LEDs, go marks the start-up cycle.
  always_comb begin
    run = (state_reg == RUN);
    go  = (state_reg == IDLE) && accept;
  end

  // Prescaler: divides clk down to one PWM tick every PRESCALE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt_reg <= '0;
    end else if (!run || tick) begin
      ps_cnt_reg <= '0;
    end else begin
      ps_cnt_reg <= ps_cnt_reg + PW'(1);
    end
  end

  // Frame counter: 0..254 on ticks, held at 0 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_reg <= '0;
    end else if (!run || wrap) begin
      pwm_cnt_reg <= '0;
    end else if (tick) begin
      pwm_cnt_reg <= pwm_cnt_reg + DUTY_W'(1);
    end
  end

  // Colour buffering: start-up loads straight into active; in RUN a word
  // waits in pending and moves to active at the frame wrap. A capture can
  // only happen with pending empty, so it never competes with the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg    <= '0;
      pending_reg   <= '0;
      pend_full_reg <= 1'b0;
    end else if (go) begin
      active_reg <= rgb;
    end else if (run) begin
      if (wrap && pend_full_reg) begin
        active_reg    <= pending_reg;
        pend_full_reg <= 1'b0;
      end
      if (accept) begin
        pending_reg   <= rgb;
        pend_full_reg <= 1'b1;
      end
    end
  end

  // Frame marker: high in the first cycle the frame counter holds 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= go || wrap;
    end
  end

  assign frame_start = frame_start_reg;

  // Channel gi drives duty byte gi: 0 blue, 1 green, 2 red.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      pwm_channel u_chan (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (run),
        .count(pwm_cnt_reg),
        .duty (active_reg[gi*DUTY_W +: DUTY_W]),
        .led  (led_vec[gi])
      );
    end
  endgenerate

  assign led_r = led_vec[2];
  assign led_g = led_vec[1];
  assign led_b = led_vec[0];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: one instance with PRESCALE=1 and one with
// PRESCALE=4 share all inputs. A frame-arithmetic reference model predicts
// every output of both each cycle; directed steps add frame-level counts.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rgb_valid = 1'b0;
  logic [23:0] rgb = '0;
  logic [1:0]  led_r, led_g, led_b, frame_start, rgb_ready;

  int checks = 0;
  int failures = 0;

  rgb_pwm_driver #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rgb(rgb), .rgb_valid(rgb_valid),
    .rgb_ready(rgb_ready[0]), .led_r(led_r[0]), .led_g(led_g[0]),
    .led_b(led_b[0]), .frame_start(frame_start[0])
  );

  rgb_pwm_driver #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rgb(rgb), .rgb_valid(rgb_valid),
    .rgb_ready(rgb_ready[1]), .led_r(led_r[1]), .led_g(led_g[1]),
    .led_b(led_b[1]), .frame_start(frame_start[1])
  );

  always #5 clk = ~clk;

  // Reference model state: k counts clk cycles since the run started.
  bit          m_run[2];
  int unsigned m_k[2];
  logic [23:0] m_act[2];
  logic [23:0] m_pend[2];
  bit          m_pf[2];
  logic        e_r[2], e_g[2], e_b[2], e_fs[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pof(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_k[i] = 0; m_act[i] = '0; m_pend[i] = '0; m_pf[i] = 0;
      e_r[i] = 0; e_g[i] = 0; e_b[i] = 0; e_fs[i] = 0;
    end
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input logic v, input logic [23:0] d);
    int p;
    int frame;
    int cnt;
    bit wrap;
    bit acc;
    for (int i = 0; i < 2; i++) begin
      p     = pof(i);
      frame = 255 * p;
      cnt   = (int'(m_k[i]) / p) % 255;
      wrap  = m_run[i] && ((int'(m_k[i]) % frame) == frame - 1);
      acc   = v && !m_pf[i];
      e_r[i]  = m_run[i] && (cnt < int'(m_act[i][23:16]));
      e_g[i]  = m_run[i] && (cnt < int'(m_act[i][15:8]));
      e_b[i]  = m_run[i] && (cnt < int'(m_act[i][7:0]));
      e_fs[i] = (!m_run[i] && acc) || wrap;
      if (!m_run[i]) begin
        if (acc) begin
          m_run[i] = 1; m_k[i] = 0; m_act[i] = d;
        end
      end else begin
        if (wrap && m_pf[i]) begin
          m_act[i] = m_pend[i]; m_pf[i] = 0;
        end
        if (acc) begin
          m_pend[i] = d; m_pf[i] = 1;
        end
        m_k[i]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("led_r[%0d]", i), 32'(led_r[i]), 32'(e_r[i]));
      chk($sformatf("led_g[%0d]", i), 32'(led_g[i]), 32'(e_g[i]));
      chk($sformatf("led_b[%0d]", i), 32'(led_b[i]), 32'(e_b[i]));
      chk($sformatf("frame_start[%0d]", i), 32'(frame_start[i]), 32'(e_fs[i]));
      chk($sformatf("rgb_ready[%0d]", i), 32'(rgb_ready[i]), 32'(!m_pf[i]));
    end
  endtask

  task automatic cyc(input logic v, input logic [23:0] d);
    rgb_valid = v;
    rgb = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    compare_all();
  endtask

  // Run until the next edge of the PRESCALE=1 instance is a frame wrap.
  task automatic to_wrap();
    int n = 0;
    while (!(m_run[0] && (m_k[0] % 255 == 254)) && n < 1200) begin
      cyc(1'b0, 24'h0);
      n++;
    end
    chk("wrap_bound", 32'(n < 1200), 32'd1);
  endtask

  // Count PRESCALE=1 LED-high cycles and frame_start pulses over 255 cycles.
  task automatic frame_count(input logic v0, input logic [23:0] d0,
                             output int nr, output int ng, output int nb, output int nf);
    nr = 0; ng = 0; nb = 0; nf = 0;
    for (int j = 0; j < 255; j++) begin
      if (j == 0) cyc(v0, d0);
      else        cyc(1'b0, 24'h0);
      nr += int'(led_r[0]); ng += int'(led_g[0]); nb += int'(led_b[0]);
      nf += int'(frame_start[0]);
    end
  endtask

  initial begin
    int nr, ng, nb, nf, s;

    // Reset held, then released: idle, ready, silent.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) cyc(1'b0, 24'h0);
    chk("idle_no_fs", 32'(frame_start), 32'd0);

    // First word starts the PWM; check one full frame of duties.
    cyc(1'b1, 24'hFF_80_00);
    chk("start_fs", 32'(frame_start[0]), 32'd1);
    frame_count(1'b0, 24'h0, nr, ng, nb, nf);
    chk("duty_r255", nr, 255);
    chk("duty_g128", ng, 128);
    chk("duty_b0", nb, 0);
    chk("frame_period", nf, 1);

    // Buffer: second word dropped, first lands at the wrap.
    cyc(1'b1, 24'h10_10_10);
    chk("ready_low", 32'(rgb_ready[0]), 32'd0);
    cyc(1'b1, 24'h20_20_20);
    to_wrap();
    chk("ready_low_prewrap", 32'(rgb_ready[0]), 32'd0);
    cyc(1'b0, 24'h0);
    chk("ready_after_wrap", 32'(rgb_ready[0]), 32'd1);
    frame_count(1'b0, 24'h0, nr, ng, nb, nf);
    chk("buf_r16", nr, 16);
    chk("buf_g16", ng, 16);
    chk("buf_b16", nb, 16);

    // Wrap with pending full: offered word waits and is taken next cycle.
    cyc(1'b1, 24'h40_00_00);
    to_wrap();
    cyc(1'b1, 24'h00_FF_00);
    chk("coll_fs", 32'(frame_start[0]), 32'd1);
    frame_count(1'b1, 24'h00_FF_00, nr, ng, nb, nf);
    chk("coll_r64", nr, 64);
    chk("coll_g0", ng, 0);
    frame_count(1'b0, 24'h0, nr, ng, nb, nf);
    chk("coll_next_r0", nr, 0);
    chk("coll_next_g255", ng, 255);

    // Capture in the wrap cycle with pending empty: applied one frame later.
    to_wrap();
    cyc(1'b1, 24'h00_00_80);
    chk("cap_wrap_ready", 32'(rgb_ready[0]), 32'd0);
    frame_count(1'b0, 24'h0, nr, ng, nb, nf);
    chk("cap_old_g255", ng, 255);
    chk("cap_old_b0", nb, 0);
    frame_count(1'b0, 24'h0, nr, ng, nb, nf);
    chk("cap_new_b128", nb, 128);

    // Mid-frame reset: LEDs drop without waiting for a clock edge.
    for (int j = 0; j < 10; j++) cyc(1'b0, 24'h0);
    chk("pre_rst_led_b", 32'(led_b[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_leds", {26'd0, led_r, led_g, led_b}, 32'd0);
    chk("async_ready", 32'(rgb_ready), 32'd3);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    s = 0;
    for (int j = 0; j < 300; j++) begin
      cyc(1'b0, 24'h0);
      s += int'(led_r[0]) + int'(led_g[0]) + int'(led_b[0]) + int'(led_b[1]) + int'(frame_start[0]);
    end
    chk("no_restore", s, 0);

    // Prescale: duty 1 gives PRESCALE clk high per frame.
    cyc(1'b1, 24'h01_00_00);
    nr = 0; nf = 0; ng = 0;
    for (int j = 0; j < 1020; j++) begin
      cyc(1'b0, 24'h0);
      nr += int'(led_r[1]); nf += int'(frame_start[1]); ng += int'(led_r[0]);
    end
    chk("ps4_r_high", nr, 4);
    chk("ps4_frames", nf, 1);
    chk("ps1_r_high", ng, 4);

    // Random traffic against the model.
    for (int j = 0; j < 3000; j++) begin
      cyc(($urandom_range(0, 11) == 0), 24'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
